// File: rtl/spi_slave_responder.sv
// SPI slave responder: returns a byte on MISO while capturing the MOSI byte.
// The master drives data on sclk rise and samples on sclk fall, and this block
// does the same. sclk/cs/mosi are oversampled on clk through a synchronizer.
module spi_slave_responder #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sclk,
  input  logic              i_cs,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_underrun,
  output logic              o_abort,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   w_sclk_s, w_cs_s, w_mosi_s;
  logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  logic                   r_hold_full;
  logic [DATA_W-1:0]      r_hold;
  logic                   w_load;

  state_t                 r_state;
  logic [DATA_W-1:0]      r_shreg, r_rxsh;
  logic [CNT_W-1:0]       r_cnt;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_d;

  // Frame start consumes the holding register only if it already held a byte.
  assign w_load      = (r_state == S_IDLE) && w_cs_fall && r_hold_full;
  assign o_tx_ready  = ~r_hold_full;

  // Synchronizer chains plus one edge-detect register per control signal.
  // cs resets high so reset does not fabricate a frame start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // Holding register: writes only when empty, emptied only by a frame start.
  // A write in the cs_fall cycle lands here for the next frame (no bypass).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_full <= 1'b0;
      r_hold      <= '0;
    end else begin
      if (w_load)
        r_hold_full <= 1'b0;
      if (i_tx_valid && !r_hold_full) begin
        r_hold_full <= 1'b1;
        r_hold      <= i_tx_data;
      end
    end
  end

  // Frame FSM: shifts MISO out on sclk rise, MOSI in on sclk fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_rxsh     <= '0;
      r_cnt      <= '0;
      o_miso     <= 1'b0;
      o_miso_oe  <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_underrun <= 1'b0;
      o_abort    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_underrun <= 1'b0;
      o_abort    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_miso    <= 1'b0;
          o_miso_oe <= 1'b0;
          r_cnt     <= '0;
          if (w_cs_fall) begin
            r_shreg    <= r_hold_full ? r_hold : IDLE_BYTE;
            o_underrun <= ~r_hold_full;
            r_rxsh     <= '0;
            r_state    <= S_SHIFT;
            o_busy     <= 1'b1;
            o_miso_oe  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            // Early deselect: drop the partial byte, leave rx_data alone.
            r_state   <= S_IDLE;
            o_abort   <= 1'b1;
            o_busy    <= 1'b0;
            o_miso_oe <= 1'b0;
            o_miso    <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              o_miso  <= r_shreg[DATA_W-1];
              r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            end
            if (w_sclk_fall) begin
              r_rxsh <= {r_rxsh[DATA_W-2:0], w_mosi_s};
              r_cnt  <= r_cnt + 1'b1;
              // Last bit: publish directly from the incoming sample.
              if (r_cnt == CNT_W'(DATA_W - 1)) begin
                o_rx_data  <= {r_rxsh[DATA_W-2:0], w_mosi_s};
                o_rx_valid <= 1'b1;
                o_miso     <= 1'b0;
                r_state    <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          o_miso <= 1'b0;
          if (w_cs_rise) begin
            r_state   <= S_IDLE;
            o_busy    <= 1'b0;
            o_miso_oe <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: directed scenarios plus random frames,
// compared against a byte-level model of the holding register and frames.
module tb_spi_slave_responder;

  localparam logic [7:0] IDLE_B = 8'h00;

  logic       i_clk = 1'b0;
  logic       i_rst, i_sclk, i_cs, i_mosi, i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_miso, o_miso_oe, o_tx_ready, o_rx_valid, o_underrun, o_abort, o_busy;
  logic [7:0] o_rx_data;

  spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_BYTE(IDLE_B)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_cs(i_cs), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .i_tx_data(i_tx_data),
    .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data),
    .o_rx_valid(o_rx_valid), .o_underrun(o_underrun), .o_abort(o_abort),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_err = 0;
  int n_rxv = 0, n_ur = 0, n_ab = 0;

  // Model state: one-deep holding register and last received byte.
  bit         hold_full = 0;
  logic [7:0] hold_val  = '0;
  logic [7:0] exp_rx    = '0;

  // Pulse counters, sampled mid-cycle; a pulse wider than one cycle counts twice.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      n_rxv += int'(o_rx_valid);
      n_ur  += int'(o_underrun);
      n_ab  += int'(o_abort);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_miso"},     o_miso,     0);
    check({tag, "_oe"},       o_miso_oe,  0);
    check({tag, "_tx_ready"}, o_tx_ready, 1);
    check({tag, "_rx_data"},  o_rx_data,  0);
    check({tag, "_rx_valid"}, o_rx_valid, 0);
    check({tag, "_underrun"}, o_underrun, 0);
    check({tag, "_abort"},    o_abort,    0);
    check({tag, "_busy"},     o_busy,     0);
  endtask

  task automatic load(input logic [7:0] b);
    check("tx_ready_pre", o_tx_ready, !hold_full);
    i_tx_data  = b;
    i_tx_valid = 1'b1;
    tick(1);
    i_tx_valid = 1'b0;
    if (!hold_full) begin
      hold_full = 1;
      hold_val  = b;
    end
    check("tx_ready_post", o_tx_ready, 0);
  endtask

  // Master side of one frame; sclk half-period 4 clk. mi collects miso as seen
  // at each falling edge, MSB first in mi[15].
  task automatic frame(input logic [7:0] mo, input int nbits,
                       input bit coll, input logic [7:0] cb,
                       input bit mid, input logic [7:0] mb,
                       output logic [15:0] mi, output logic oe3);
    mi   = '0;
    i_cs = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (coll && k == 2) begin
        // Lands in the cycle the slave sees its internal cs_fall strobe.
        i_tx_data  = cb;
        i_tx_valid = 1'b1;
      end
      tick(1);
      i_tx_valid = 1'b0;
    end
    check("busy_in_frame", o_busy, 1);
    check("oe_in_frame", o_miso_oe, 1);
    for (int i = 0; i < nbits; i++) begin
      i_mosi = (i < 8) ? mo[7-i] : ($urandom_range(0, 1) != 0);
      i_sclk = 1'b1;
      if (mid && i == 3) begin
        check("tx_ready_mid_pre", o_tx_ready, 1);
        i_tx_data  = mb;
        i_tx_valid = 1'b1;
        tick(1);
        i_tx_valid = 1'b0;
        check("tx_ready_mid_post", o_tx_ready, 0);
        tick(3);
      end else begin
        tick(4);
      end
      mi[15-i] = o_miso;
      i_sclk   = 1'b0;
      tick(4);
    end
    tick(2);
    i_cs = 1'b1;
    tick(3);
    oe3 = o_miso_oe;
    tick(3);
  endtask

  task automatic run_frame(input logic [7:0] mo, input int nbits,
                           input bit coll, input logic [7:0] cb,
                           input bit mid, input logic [7:0] mb);
    logic [7:0]  exp_mi;
    bit          exp_ur;
    int          rx0, ur0, ab0;
    logic [15:0] mi, mask;
    logic        oe3;
    exp_mi    = hold_full ? hold_val : IDLE_B;
    exp_ur    = !hold_full;
    hold_full = 0;
    rx0 = n_rxv; ur0 = n_ur; ab0 = n_ab;
    frame(mo, nbits, coll, cb, mid, mb, mi, oe3);
    if (coll) begin hold_full = 1; hold_val = cb; end
    if (mid)  begin hold_full = 1; hold_val = mb; end
    if (nbits >= 8) begin
      check("miso_byte", mi[15:8], exp_mi);
      exp_rx = mo;
      check("rx_valid_cnt", n_rxv - rx0, 1);
      check("abort_cnt", n_ab - ab0, 0);
      if (nbits > 8) begin
        mask = '0;
        for (int i = 8; i < nbits; i++) mask[15-i] = 1'b1;
        check("miso_done_zero", mi & mask, 0);
      end
    end else begin
      mask = '0;
      for (int i = 0; i < nbits; i++) mask[15-i] = 1'b1;
      check("miso_partial", mi & mask, {exp_mi, 8'h00} & mask);
      check("rx_valid_cnt_abort", n_rxv - rx0, 0);
      check("abort_cnt", n_ab - ab0, 1);
    end
    check("rx_data", o_rx_data, exp_rx);
    check("underrun_cnt", n_ur - ur0, exp_ur);
    check("oe_after_cs", oe3, 0);
    check("busy_after", o_busy, 0);
    check("tx_ready_after", o_tx_ready, !hold_full);
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ab0, rx0;
    logic [7:0] b;
    i_rst = 1'b1; i_cs = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
    i_tx_valid = 1'b0; i_tx_data = '0;
    tick(3);
    chk_reset_outputs("rst");
    i_rst = 1'b0;
    tick(3);
    chk_reset_outputs("post_rst");

    // Basic frame.
    load(8'hA5);
    run_frame(8'h3C, 8, 0, 8'h00, 0, 8'h00);
    // Underrun.
    run_frame(8'hFF, 8, 0, 8'h00, 0, 8'h00);
    // Abort after three bits.
    load(8'h3A);
    run_frame(8'h96, 3, 0, 8'h00, 0, 8'h00);
    // Back-to-back with a load during frame 1.
    load(8'h81);
    run_frame(8'h12, 8, 0, 8'h00, 1, 8'h7E);
    run_frame(8'h34, 8, 0, 8'h00, 0, 8'h00);
    // Extra sclk cycles.
    load(8'h5A);
    run_frame(8'hC3, 10, 0, 8'h00, 0, 8'h00);
    // Load collision with cs_fall.
    run_frame(8'h0F, 8, 1, 8'hE7, 0, 8'h00);
    run_frame(8'hF0, 8, 0, 8'h00, 0, 8'h00);

    // Reset mid-frame.
    load(8'h55);
    ab0 = n_ab; rx0 = n_rxv;
    i_cs = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      i_mosi = ($urandom_range(0, 1) != 0);
      i_sclk = 1'b1; tick(4);
      i_sclk = 1'b0; tick(4);
    end
    i_rst = 1'b1;
    tick(1);
    chk_reset_outputs("midrst");
    i_cs = 1'b1; i_sclk = 1'b0;
    tick(3);
    i_rst = 1'b0;
    hold_full = 0;
    exp_rx    = '0;
    tick(6);
    check("midrst_abort_cnt", n_ab - ab0, 0);
    check("midrst_rx_cnt", n_rxv - rx0, 0);
    load(8'h99);
    run_frame(8'h66, 8, 0, 8'h00, 0, 8'h00);

    // Random frames.
    for (int f = 0; f < 20; f++) begin
      if (!hold_full && $urandom_range(0, 1) != 0) begin
        b = 8'($urandom);
        load(b);
      end
      run_frame(8'($urandom), 8, 0, 8'h00, $urandom_range(0, 3) == 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
